alu_sequencer: RTL and testbench

- Sequences the 8-bit constant-operand ALU through a short stored program of (operation, constant-select) steps.
- Feeds each result back as the next step's input (accumulator loop).
- Sits between a host/FSM that loads the program and issues start, and the ALU datapath it owns.
- Reports the final result, zero status, step count and error flag with a start/busy/done handshake.

---
 rtl/alu_seq_pkg.sv | 39 +++
 rtl/alu_const_unit.sv | 39 +++
 rtl/alu_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// +----------------------------------------------------------------------+
// | alu_seq_pkg : shared types and constant table for alu_sequencer       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_t;

    typedef struct packed {
        alu_op_t    op;
        logic [1:0] csel;
    } prog_entry_t;

    function automatic logic [7:0] const_of(input logic [1:0] csel);
        case (csel)
            2'd0:    const_of = 8'd1;
            2'd1:    const_of = 8'd3;
            2'd2:    const_of = 8'd5;
            default: const_of = 8'd7;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_const_unit.sv
// +----------------------------------------------------------------------+
// | alu_const_unit : combinational 8-bit ALU against a selected constant  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_const_unit
    import alu_seq_pkg::*;
(
    input  logic [7:0] a,
    input  alu_op_t    op,
    input  logic [1:0] csel,
    output logic [7:0] y,
    output logic       zero,
    output logic       invalid
);

    logic [7:0] k;

    always_comb begin
        k       = const_of(csel);
        y       = 8'h00;
        invalid = 1'b0;
        case (op)
            OP_ADD:  y = a + k;
            OP_SUB:  y = a - k;
            OP_NAND: y = ~(a & k);
            OP_NOR:  y = ~(a | k);
            OP_XOR:  y = a ^ k;
            // Undefined opcodes force a zero result and raise invalid
            default: invalid = 1'b1;
        endcase
    end

    assign zero = (y == 8'h00);

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// +----------------------------------------------------------------------+
// | alu_sequencer : runs a stored (op, csel) program through the ALU      |
// |                 with the result fed back as an accumulator.           |
// | Option macro  : ALU_SEQ_EARLY_STOP_EN (stop on a zero step result)    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [2:0]    prog_op,
    input  logic [1:0]    prog_csel,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic [7:0]    load_value,
    output logic          busy,
    output logic          done,
    output logic [7:0]    result,
    output logic          status,
    output logic [AW:0]   step_cnt,
    output logic          err
);

    localparam logic [AW:0]   LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PC_ONE  = AW'(1);

    seq_state_t    state_q, state_d;
    logic [7:0]    acc_q,   acc_d;
    logic [AW-1:0] pc_q,    pc_d;
    logic [AW:0]   step_q,  step_d;
    logic [AW:0]   len_q,   len_d;
    logic          err_q,   err_d;

    prog_entry_t   mem_q [DEPTH];
    prog_entry_t   cur;
    logic [7:0]    alu_y;
    logic          alu_zero;
    logic          alu_invalid;
    logic          early_stop;
    logic [AW:0]   len_clip;

    // Program store has no reset; only runs lock it out
    always_ff @(posedge clk) begin
        if (prog_we && (state_q != S_RUN)) begin
            mem_q[prog_addr] <= '{op: alu_op_t'(prog_op), csel: prog_csel};
        end
    end

    assign cur = mem_q[pc_q];

    alu_const_unit u_alu (
        .a       (acc_q),
        .op      (cur.op),
        .csel    (cur.csel),
        .y       (alu_y),
        .zero    (alu_zero),
        .invalid (alu_invalid)
    );

`ifdef ALU_SEQ_EARLY_STOP_EN
    assign early_stop = alu_zero;
`else
    logic unused_zero;
    assign early_stop  = 1'b0;
    assign unused_zero = alu_zero;
`endif

    assign len_clip = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        pc_d    = pc_q;
        step_d  = step_q;
        len_d   = len_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = load_value;
                    pc_d    = '0;
                    step_d  = '0;
                    err_d   = 1'b0;
                    len_d   = len_clip;
                    state_d = (len_clip == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                acc_d  = alu_y;
                pc_d   = pc_q + PC_ONE;
                step_d = step_q + CNT_ONE;
                if (alu_invalid) begin
                    err_d = 1'b1;
                end
                if (({1'b0, pc_q} == (len_q - CNT_ONE)) || early_stop) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= 8'h00;
            pc_q    <= '0;
            step_q  <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            pc_q    <= pc_d;
            step_q  <= step_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign result   = acc_q;
    assign status   = (acc_q == 8'h00);
    assign step_cnt = step_q;
    assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_alu_sequencer : scoreboard bench for alu_sequencer                 |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_alu_sequencer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [2:0]    prog_op;
    logic [1:0]    prog_csel;
    logic [AW:0]   prog_len;
    logic          start;
    logic [7:0]    load_value;
    logic          busy;
    logic          done;
    logic [7:0]    result;
    logic          status;
    logic [AW:0]   step_cnt;
    logic          err;

    always #5 clk = ~clk;

    alu_sequencer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_op    (prog_op),
        .prog_csel  (prog_csel),
        .prog_len   (prog_len),
        .start      (start),
        .load_value (load_value),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .status     (status),
        .step_cnt   (step_cnt),
        .err        (err)
    );

    typedef struct packed {
        logic [7:0]  res;
        logic [AW:0] steps;
        logic        err;
        logic [7:0]  lat;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] trace_q [$];
    logic [2:0] op_m [DEPTH];
    logic [1:0] cs_m [DEPTH];
    int         n_vec  = 0;
    int         n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [2:0] op,
                                           input logic [1:0] cs, output logic inv);
        logic [7:0] k;
        k   = {5'd0, cs, 1'b1};
        inv = 1'b0;
        case (op)
            3'd0:    ref_alu = a + k;
            3'd1:    ref_alu = a - k;
            3'd2:    ref_alu = ~(a & k);
            3'd3:    ref_alu = ~(a | k);
            3'd4:    ref_alu = a ^ k;
            default: begin ref_alu = 8'h00; inv = 1'b1; end
        endcase
    endfunction

    task automatic write_prog(input int addr, input logic [2:0] op, input logic [1:0] cs);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = AW'(addr);
        prog_op   = op;
        prog_csel = cs;
        @(posedge clk);
        #1;
        prog_we   = 1'b0;
        op_m[addr] = op;
        cs_m[addr] = cs;
    endtask

    task automatic do_run(input string name, input logic [7:0] load, input logic [AW:0] len,
                          input bit poke_done);
        exp_t       e;
        logic [7:0] a;
        logic       inv;
        int         n;
        int         eff;
        int         cyc;
        eff   = (int'(len) > DEPTH) ? DEPTH : int'(len);
        a     = load;
        e.err = 1'b0;
        n     = 0;
        trace_q.push_back(a);
        for (int i = 0; i < eff; i++) begin
            a = ref_alu(a, op_m[i], cs_m[i], inv);
            if (inv) e.err = 1'b1;
            n++;
            trace_q.push_back(a);
`ifdef ALU_SEQ_EARLY_STOP_EN
            if (a == 8'h00) break;
`endif
        end
        e.res   = a;
        e.steps = (AW+1)'(n);
        e.lat   = 8'(n);
        sb.push_back(e);

        @(negedge clk);
        start      = 1'b1;
        load_value = load;
        prog_len   = len;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        forever begin
            if (trace_q.size() > 0) check({name, ".acc"}, result, trace_q.pop_front());
            if (done || cyc >= 40) break;
            @(posedge clk);
            #1;
            cyc++;
        end
        e = sb.pop_front();
        check({name, ".done_seen"}, done, 1);
        check({name, ".latency"}, cyc, e.lat);
        check({name, ".result"}, result, e.res);
        check({name, ".status"}, status, e.res == 8'h00);
        check({name, ".step_cnt"}, step_cnt, e.steps);
        check({name, ".err"}, err, e.err);
        check({name, ".busy_done"}, busy, 1);
        check({name, ".trace_left"}, trace_q.size(), 0);
        trace_q.delete();
        if (poke_done) begin
            @(negedge clk);
            start      = 1'b1;
            load_value = 8'hA5;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, ".done_pulse"}, done, 0);
        check({name, ".busy_idle"}, busy, 0);
        check({name, ".hold"}, result, e.res);
    endtask

    initial begin
        reset      = 1'b1;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_op    = '0;
        prog_csel  = '0;
        prog_len   = '0;
        start      = 1'b0;
        load_value = '0;
        for (int i = 0; i < DEPTH; i++) begin
            op_m[i] = 3'd0;
            cs_m[i] = 2'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst.result", result, 8'h00);
        check("rst.status", status, 1);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.step_cnt", step_cnt, 0);
        check("rst.err", err, 0);
        @(negedge clk);
        reset = 1'b0;

        write_prog(0, 3'd0, 2'd0);
        write_prog(1, 3'd0, 2'd3);
        write_prog(2, 3'd4, 2'd2);
        do_run("add_add_xor", 8'h10, 4'd3, 1'b1);

        write_prog(0, 3'd1, 2'd1);
        do_run("sub_wrap", 8'h02, 4'd1, 1'b0);

        write_prog(0, 3'd2, 2'd3);
        write_prog(1, 3'd3, 2'd0);
        do_run("nand_nor", 8'hFF, 4'd2, 1'b0);

        write_prog(0, 3'd1, 2'd0);
        write_prog(1, 3'd0, 2'd3);
        write_prog(2, 3'd0, 2'd3);
        do_run("zero_step", 8'h01, 4'd3, 1'b0);

        write_prog(0, 3'd6, 2'd1);
        do_run("invalid_op", 8'h55, 4'd1, 1'b0);
        do_run("len_zero", 8'h33, 4'd0, 1'b0);

        for (int i = 0; i < DEPTH; i++) write_prog(i, 3'd0, 2'd0);
        do_run("len_clip", 8'h00, 4'd15, 1'b0);
        do_run("len_full", 8'hF0, 4'd8, 1'b0);

        // Abort a run with reset while start and prog_we are being driven
        @(negedge clk);
        start      = 1'b1;
        load_value = 8'h20;
        prog_len   = 4'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        start      = 1'b1;
        load_value = 8'h99;
        prog_we    = 1'b1;
        prog_addr  = '0;
        prog_op    = 3'd4;
        prog_csel  = 2'd3;
        @(posedge clk);
        #1;
        start   = 1'b0;
        prog_we = 1'b0;
        check("abort.acc", result, 8'h21);
        check("abort.step_cnt", step_cnt, 1);
        check("abort.busy", busy, 1);
        reset = 1'b1;
        #1;
        check("abort.busy_rst", busy, 0);
        check("abort.result_rst", result, 8'h00);
        check("abort.status_rst", status, 1);
        check("abort.step_rst", step_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("abort.no_done", done, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort.idle", busy, 0);
        check("abort.no_done_after", done, 0);
        do_run("prog_kept", 8'h00, 4'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
